gcd_axi_operand_writer: RTL and testbench

// - AXI4 write initiator that pushes one wide GCD operand into the wrapper's 64-bit AXI data slave.
// - Packs OPERAND LSB-first into a single INCR burst and waits for the write response.
// - Reports completion with a one-cycle DONE pulse.
// - Sits in the test/host-side fabric; pairs with the wrapper's operand unpacker (the receiving end).

---
 rtl/gcd_axi_pkg.sv | 34 +++
 rtl/gcd_axi_operand_writer_if.sv | 41 ++++
 rtl/gcd_wide_shift_reg.sv | 32 +++
 rtl/gcd_axi_operand_writer.sv | 164 ++++++++++++++++
 tb/tb_gcd_axi_operand_writer.sv | 296 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gcd_axi_pkg.sv
// Shared AXI constants, FSM state type and burst-geometry helpers for the
// GCD operand writer.
package gcd_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;
  localparam logic [2:0] AXI_SIZE_8B       = 3'd3;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [2:0] AXI_PROT_DEFAULT  = 3'b000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wr_state_t;

  function automatic int num_beats(input int width, input int data_w);
    return (width + data_w - 1) / data_w;
  endfunction

  // Byte strobe for the final beat: only bytes that carry operand bits are enabled.
  function automatic logic [7:0] last_strb(input int width, input int data_w);
    int         rem;
    logic [7:0] strb;
    rem  = width - (num_beats(width, data_w) - 1) * data_w;
    strb = 8'h00;
    for (int b = 0; b < 8; b++) begin
      strb[b] = ((b * 8) < rem);
    end
    return strb;
  endfunction

endpackage

// File: rtl/gcd_axi_operand_writer_if.sv
// AXI4 write-only channel bundle (AW, W, B) between the operand writer
// (master) and the wrapper's data slave.
interface gcd_axi_operand_writer_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 4,
  parameter int DATA_W = 64
);

  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bid, bresp, bvalid
  );

endinterface

// File: rtl/gcd_wide_shift_reg.sv
// Wide operand holding register: parallel load, right shift by one data word,
// lowest word presented as the current beat.
module gcd_wide_shift_reg #(
  parameter int TOTAL_W = 1280,
  parameter int DATA_W  = 64
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_load,
  input  logic               i_shift,
  input  logic [TOTAL_W-1:0] i_data,
  output logic [DATA_W-1:0]  o_word
);

  logic [TOTAL_W-1:0] r_shreg;

  // Load has priority; shifting only happens on an accepted beat so the word holds under stall.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_shreg <= '0;
    end else if (i_load) begin
      r_shreg <= i_data;
    end else if (i_shift) begin
      r_shreg <= {{DATA_W{1'b0}}, r_shreg[TOTAL_W-1:DATA_W]};
    end else begin
      r_shreg <= r_shreg;
    end
  end

  assign o_word = r_shreg[DATA_W-1:0];

endmodule

// File: rtl/gcd_axi_operand_writer.sv
// AXI4 write initiator: sends one zero-padded wide operand as a single INCR
// burst, waits for the B response and pulses o_done.
module gcd_axi_operand_writer
  import gcd_axi_pkg::*;
#(
  parameter int OPERAND_W = 1279,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [ADDR_W-1:0]       i_base_addr,
  input  logic [ID_W-1:0]         i_txn_id,
  input  logic [OPERAND_W-1:0]    i_operand,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error,
  gcd_axi_operand_writer_if.master m_axi
);

  localparam int         BEATS     = num_beats(OPERAND_W, DATA_W);
  localparam int         TOTAL_W   = BEATS * DATA_W;
  localparam logic [7:0] LAST_BEAT = 8'(BEATS - 1);
  localparam logic [7:0] LAST_STRB = last_strb(OPERAND_W, DATA_W);

  wr_state_t         r_state;
  logic [7:0]        r_beat_cnt;
  logic              r_busy;
  logic              r_done;
  logic              r_error;
  logic [ID_W-1:0]   r_awid;
  logic [ADDR_W-1:0] r_awaddr;
  logic [7:0]        r_awlen;
  logic [2:0]        r_awsize;
  logic [1:0]        r_awburst;
  logic [3:0]        r_awcache;
  logic              r_awvalid;
  logic [7:0]        r_wstrb;
  logic              r_wlast;
  logic              r_wvalid;
  logic              r_bready;

  logic               w_load;
  logic               w_shift;
  logic [TOTAL_W-1:0] w_operand_padded;
  logic [DATA_W-1:0]  w_wdata;

  // A START coinciding with the DONE pulse is dropped, so re-issue waits one cycle.
  assign w_load           = (r_state == IDLE) && i_start && !r_done;
  assign w_shift          = (r_state == DATA) && r_wvalid && m_axi.wready;
  assign w_operand_padded = TOTAL_W'(i_operand);

  gcd_wide_shift_reg #(
    .TOTAL_W (TOTAL_W),
    .DATA_W  (DATA_W)
  ) u_shreg (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_load  (w_load),
    .i_shift (w_shift),
    .i_data  (w_operand_padded),
    .o_word  (w_wdata)
  );

  // Burst sequencer: address phase, data beats, then response, all outputs registered.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= IDLE;
      r_beat_cnt <= 8'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_awid     <= '0;
      r_awaddr   <= '0;
      r_awlen    <= 8'd0;
      r_awsize   <= 3'd0;
      r_awburst  <= 2'd0;
      r_awcache  <= 4'd0;
      r_awvalid  <= 1'b0;
      r_wstrb    <= 8'h00;
      r_wlast    <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_state    <= ADDR;
            r_busy     <= 1'b1;
            r_error    <= 1'b0;
            r_beat_cnt <= 8'd0;
            r_awid     <= i_txn_id;
            r_awaddr   <= i_base_addr;
            r_awlen    <= LAST_BEAT;
            r_awsize   <= AXI_SIZE_8B;
            r_awburst  <= AXI_BURST_INCR;
            r_awcache  <= AXI_CACHE_DEFAULT;
            r_awvalid  <= 1'b1;
          end
        end
        ADDR: begin
          if (m_axi.awready) begin
            r_state   <= DATA;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wlast   <= (LAST_BEAT == 8'd0);
            r_wstrb   <= (LAST_BEAT == 8'd0) ? LAST_STRB : 8'hFF;
          end
        end
        DATA: begin
          if (w_shift) begin
            r_beat_cnt <= r_beat_cnt + 8'd1;
            if (r_wlast) begin
              r_state  <= RESP;
              r_wvalid <= 1'b0;
              r_wlast  <= 1'b0;
              r_wstrb  <= 8'h00;
              r_bready <= 1'b1;
            end else begin
              // WLAST/WSTRB are prepared one beat ahead so they sit with the word they describe.
              r_wlast <= ((r_beat_cnt + 8'd1) == LAST_BEAT);
              r_wstrb <= ((r_beat_cnt + 8'd1) == LAST_BEAT) ? LAST_STRB : 8'hFF;
            end
          end
        end
        RESP: begin
          if (m_axi.bvalid) begin
            r_state  <= IDLE;
            r_bready <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_error  <= (m_axi.bresp != AXI_RESP_OKAY) || (m_axi.bid != r_awid);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_busy  = r_busy;
  assign o_done  = r_done;
  assign o_error = r_error;

  assign m_axi.awid    = r_awid;
  assign m_axi.awaddr  = r_awaddr;
  assign m_axi.awlen   = r_awlen;
  assign m_axi.awsize  = r_awsize;
  assign m_axi.awburst = r_awburst;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = r_awcache;
  assign m_axi.awprot  = AXI_PROT_DEFAULT;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = w_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wlast   = r_wlast;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.bready  = r_bready;

endmodule

// File: tb/tb_gcd_axi_operand_writer.sv
// Self-checking bench for gcd_axi_operand_writer: directed vector table plus
// randomized bursts, all checked against a word-level model of the operand.
module tb_gcd_axi_operand_writer;

  localparam int OPERAND_W = 1279;
  localparam int DATA_W    = 64;
  localparam int ADDR_W    = 32;
  localparam int ID_W      = 4;
  localparam int BEATS     = (OPERAND_W + DATA_W - 1) / DATA_W;
  localparam int TOTAL_W   = BEATS * DATA_W;
  localparam int MAX_CYC   = 600;
  localparam int N_VEC     = 8;
  localparam int N_RAND    = 10;

  typedef struct {
    logic [OPERAND_W-1:0] operand;
    logic [ADDR_W-1:0]    addr;
    logic [ID_W-1:0]      id;
    int                   aw_delay;
    int                   w_mode;        // 0 always ready, 1 toggle, 2 random
    int                   b_delay;
    bit                   b_early;       // BVALID held high outside the response phase
    logic [1:0]           bresp;
    logic [ID_W-1:0]      bid_xor;
    int                   start_at_beat; // extra START pulse while bursting, -1 none
    bit                   start_with_done;
    int                   reset_at_beat; // -1 none
    bit                   exp_error;
    int                   exp_done_cyc;  // 0 means not checked
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 start;
  logic [ADDR_W-1:0]    base_addr;
  logic [ID_W-1:0]      txn_id;
  logic [OPERAND_W-1:0] operand;
  logic                 busy;
  logic                 done;
  logic                 error;

  int total = 0;
  int bad   = 0;

  gcd_axi_operand_writer_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DATA_W(DATA_W)) axi ();

  gcd_axi_operand_writer #(
    .OPERAND_W (OPERAND_W),
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .ID_W      (ID_W)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_base_addr (base_addr),
    .i_txn_id    (txn_id),
    .i_operand   (operand),
    .o_busy      (busy),
    .o_done      (done),
    .o_error     (error),
    .m_axi       (axi)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [TOTAL_W-1:0] act,
                            input logic [TOTAL_W-1:0] exp);
    int first_bad;
    first_bad = -1;
    total++;
    for (int k = BEATS - 1; k >= 0; k--) begin
      if (act[k*DATA_W +: DATA_W] !== exp[k*DATA_W +: DATA_W]) first_bad = k;
    end
    if (first_bad >= 0) begin
      bad++;
      $display("FAIL %s: word %0d got %h expected %h", name, first_bad,
               act[first_bad*DATA_W +: DATA_W], exp[first_bad*DATA_W +: DATA_W]);
    end
  endtask

  // Reference: beat k carries bits [64k+63:64k] of the zero-extended operand.
  function automatic logic [DATA_W-1:0] model_word(input logic [OPERAND_W-1:0] op, input int k);
    logic [TOTAL_W-1:0] padded;
    padded = '0;
    padded[OPERAND_W-1:0] = op;
    return padded[k*DATA_W +: DATA_W];
  endfunction

  function automatic logic [7:0] model_strb(input int k);
    int rem_bits;
    int nbytes;
    rem_bits = OPERAND_W - (BEATS - 1) * DATA_W;
    nbytes   = (rem_bits + 7) / 8;
    if (k != BEATS - 1 || nbytes >= 8) return 8'hFF;
    return 8'((1 << nbytes) - 1);
  endfunction

  function automatic logic [OPERAND_W-1:0] seq_bytes();
    logic [TOTAL_W-1:0] t;
    for (int i = 0; i < TOTAL_W / 8; i++) t[8*i +: 8] = 8'(i);
    return t[OPERAND_W-1:0];
  endfunction

  function automatic logic [OPERAND_W-1:0] rand_op();
    logic [TOTAL_W-1:0] t;
    for (int i = 0; i < TOTAL_W / 32; i++) t[32*i +: 32] = $urandom;
    return t[OPERAND_W-1:0];
  endfunction

  function automatic vec_t base_vec(input logic [OPERAND_W-1:0] op, input logic [ADDR_W-1:0] a,
                                    input logic [ID_W-1:0] id);
    vec_t v;
    v.operand = op;          v.addr = a;               v.id = id;
    v.aw_delay = 0;          v.w_mode = 0;             v.b_delay = 0;
    v.b_early = 1'b0;        v.bresp = 2'b00;          v.bid_xor = '0;
    v.start_at_beat = -1;    v.start_with_done = 1'b0; v.reset_at_beat = -1;
    v.exp_error = 1'b0;      v.exp_done_cyc = 0;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    logic [DATA_W-1:0]  got_q[$];
    logic [TOTAL_W-1:0] got_all;
    int cyc, aw_wait, b_wait, aw_hs_cyc, b_hs_cyc, idx;
    bit finished, aborted, restarted, first_w;
    aw_wait = 0; b_wait = 0; aw_hs_cyc = -10; b_hs_cyc = -10;
    finished = 1'b0; aborted = 1'b0; restarted = 1'b0; first_w = 1'b0;

    @(negedge clk);
    operand = v.operand; base_addr = v.addr; txn_id = v.id; start = 1'b1;
    axi.awready = 1'b0; axi.wready = 1'b0;
    axi.bvalid = v.b_early; axi.bresp = v.bresp; axi.bid = v.id ^ v.bid_xor;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    check({tag, " awvalid_after_start"}, 64'(axi.awvalid), 64'd1);
    check({tag, " error_cleared_on_start"}, 64'(error), 64'd0);

    while (!finished && !aborted && cyc < MAX_CYC) begin
      if (v.reset_at_beat >= 0 && got_q.size() == v.reset_at_beat) begin
        reset = 1'b1;
        axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0;
        @(negedge clk);
        check({tag, " rst_awvalid"}, 64'(axi.awvalid), 64'd0);
        check({tag, " rst_wvalid"},  64'(axi.wvalid),  64'd0);
        check({tag, " rst_bready"},  64'(axi.bready),  64'd0);
        check({tag, " rst_busy"},    64'(busy),        64'd0);
        check({tag, " rst_done"},    64'(done),        64'd0);
        reset = 1'b0;
        aborted = 1'b1;
      end else if (done) begin
        check({tag, " done_after_b"}, 64'(cyc), 64'(b_hs_cyc + 1));
        check({tag, " error"}, 64'(error), 64'(v.exp_error));
        check({tag, " busy_falls_with_done"}, 64'(busy), 64'd0);
        if (v.exp_done_cyc > 0) check({tag, " done_latency"}, 64'(cyc), 64'(v.exp_done_cyc));
        axi.bvalid = 1'b0;
        if (v.start_with_done) begin
          start = 1'b1; operand = ~v.operand;
        end
        finished = 1'b1;
      end else begin
        start = 1'b0;
        check({tag, " busy_held"}, 64'(busy), 64'd1);
        if (axi.awvalid) begin
          check({tag, " aw_w_exclusive"}, 64'(axi.wvalid), 64'd0);
          check({tag, " awaddr"},  64'(axi.awaddr),  64'(v.addr));
          check({tag, " awid"},    64'(axi.awid),    64'(v.id));
          check({tag, " awlen"},   64'(axi.awlen),   64'(BEATS - 1));
          check({tag, " awsize"},  64'(axi.awsize),  64'd3);
          check({tag, " awburst"}, 64'(axi.awburst), 64'd1);
          check({tag, " awcache"}, 64'(axi.awcache), 64'd3);
          check({tag, " awlock_prot"}, 64'({axi.awlock, axi.awprot}), 64'd0);
          axi.awready = (aw_wait >= v.aw_delay);
          aw_wait++;
          if (axi.awready) aw_hs_cyc = cyc;
        end else begin
          axi.awready = (v.aw_delay == 0);
        end

        if (axi.wvalid) begin
          idx = got_q.size();
          if (!first_w) begin
            first_w = 1'b1;
            check({tag, " first_w_latency"}, 64'(cyc), 64'(aw_hs_cyc + 1));
          end
          check({tag, " wdata"}, axi.wdata, model_word(v.operand, idx));
          check({tag, " wstrb"}, 64'(axi.wstrb), 64'(model_strb(idx)));
          check({tag, " wlast"}, 64'(axi.wlast), 64'(idx == BEATS - 1));
          case (v.w_mode)
            0:       axi.wready = 1'b1;
            1:       axi.wready = ~axi.wready;
            default: axi.wready = 1'($urandom_range(0, 1));
          endcase
          if (axi.wready) got_q.push_back(axi.wdata);
        end else begin
          axi.wready = (v.w_mode == 0);
        end

        if (axi.bready) begin
          check({tag, " bready_after_last"}, 64'(got_q.size()), 64'(BEATS));
          axi.bvalid = v.b_early || (b_wait >= v.b_delay);
          b_wait++;
          if (axi.bvalid) b_hs_cyc = cyc;
        end else begin
          axi.bvalid = v.b_early;
        end

        if (!restarted && v.start_at_beat >= 0 && got_q.size() == v.start_at_beat && axi.wvalid) begin
          start = 1'b1; operand = ~v.operand; base_addr = ~v.addr; txn_id = ~v.id;
          restarted = 1'b1;
        end
        @(negedge clk);
        cyc++;
      end
    end

    check({tag, " completed"}, 64'(finished | aborted), 64'd1);
    if (finished) begin
      check({tag, " beat_count"}, 64'(got_q.size()), 64'(BEATS));
      for (int k = 0; k < BEATS; k++) got_all[k*DATA_W +: DATA_W] = (k < got_q.size()) ? got_q[k] : '0;
      check_wide({tag, " scoreboard"}, got_all, TOTAL_W'(v.operand));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        start = 1'b0;
        check({tag, " done_single"}, 64'(done), 64'd0);
        check({tag, " idle_busy"}, 64'(busy), 64'd0);
        check({tag, " no_requeue"}, 64'(axi.awvalid), 64'd0);
        check({tag, " error_hold"}, 64'(error), 64'(v.exp_error));
      end
    end
  endtask

  initial begin
    vec_t vecs[N_VEC];
    vec_t v;

    reset = 1'b1; start = 1'b0; operand = '0; base_addr = '0; txn_id = '0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00; axi.bid = '0;
    repeat (3) @(negedge clk);
    check("reset busy",    64'(busy),        64'd0);
    check("reset done",    64'(done),        64'd0);
    check("reset error",   64'(error),       64'd0);
    check("reset awvalid", 64'(axi.awvalid), 64'd0);
    check("reset wvalid",  64'(axi.wvalid),  64'd0);
    check("reset bready",  64'(axi.bready),  64'd0);
    check("reset aw_fields", 64'({axi.awlen, axi.awsize, axi.awburst, axi.awcache, axi.awid}), 64'd0);
    check("reset w_fields",  64'({axi.wstrb, axi.wlast}), 64'd0);
    check("reset wdata",   axi.wdata, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    vecs[0] = base_vec(seq_bytes(), 32'h4000_0000, 4'h3);
    vecs[0].b_early = 1'b1; vecs[0].exp_done_cyc = 23;
    vecs[1] = base_vec(rand_op(), 32'h4000_1000, 4'h5);
    vecs[1].aw_delay = 5; vecs[1].w_mode = 1; vecs[1].b_delay = 2;
    vecs[2] = base_vec(rand_op(), 32'h4000_2000, 4'h9);
    vecs[2].bresp = 2'b10; vecs[2].exp_error = 1'b1; vecs[2].exp_done_cyc = 23;
    vecs[3] = base_vec(rand_op(), 32'h4000_3000, 4'hA);
    vecs[3].bid_xor = 4'h1; vecs[3].exp_error = 1'b1;
    vecs[4] = base_vec(rand_op(), 32'h4000_4000, 4'h6);
    vecs[4].w_mode = 1; vecs[4].start_at_beat = 5;
    vecs[5] = base_vec(rand_op(), 32'h4000_5000, 4'hC);
    vecs[5].start_with_done = 1'b1; vecs[5].exp_done_cyc = 23;
    vecs[6] = base_vec(rand_op(), 32'h4000_6000, 4'h2);
    vecs[6].reset_at_beat = 7;
    vecs[7] = base_vec(rand_op(), 32'h4000_7000, 4'hF);
    vecs[7].exp_done_cyc = 23;

    for (int i = 0; i < N_VEC; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    for (int i = 0; i < N_RAND; i++) begin
      v = base_vec(rand_op(), $urandom, 4'($urandom));
      v.aw_delay = $urandom_range(0, 4);
      v.w_mode   = 2;
      v.b_delay  = $urandom_range(0, 3);
      v.b_early  = 1'($urandom_range(0, 1));
      v.bresp    = 2'($urandom);
      v.bid_xor  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      v.exp_error = (v.bresp != 2'b00) || (v.bid_xor != 4'h0);
      run_txn(v, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
